// File: rtl/tag_hop_scheduler.sv
// tag_hop_scheduler: per-hop NCO tune sequencer for the tag RX chain.
// Optional TAG_HOP_SCHED_SHUFFLE_EN adds cfg_seed and XOR-permutes full sweeps.
module tag_hop_scheduler #(
   parameter int PHASE_WIDTH   = 24,
   parameter int NUM_HOPS      = 64,
   parameter int HOP_IDX_WIDTH = 6,
   parameter int ACK_TIMEOUT   = 1023
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [1:0]               rx_state,
   input  logic [HOP_IDX_WIDTH:0]   cfg_num_hops,
   input  logic [PHASE_WIDTH-1:0]   cfg_base_inc,
   input  logic [PHASE_WIDTH-1:0]   cfg_step_inc,
`ifdef TAG_HOP_SCHED_SHUFFLE_EN
   input  logic [HOP_IDX_WIDTH-1:0] cfg_seed,
`endif
   output logic                     tune_req,
   output logic [PHASE_WIDTH-1:0]   tune_phase_inc,
   input  logic                     tune_ack,
   output logic [HOP_IDX_WIDTH-1:0] hop_idx,
   output logic                     hop_active,
   output logic                     sweep_done,
   output logic                     tune_err
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(ACK_TIMEOUT);
   localparam logic [HOP_IDX_WIDTH:0] NH_MAX = (HOP_IDX_WIDTH+1)'(NUM_HOPS);
   localparam logic [HOP_IDX_WIDTH:0] NH_ONE = (HOP_IDX_WIDTH+1)'(1);
   localparam logic [HOP_IDX_WIDTH-1:0] SEQ_ONE = HOP_IDX_WIDTH'(1);

   localparam logic [1:0] RX_INIT = 2'b00;
   localparam logic [1:0] RX_LOC  = 2'b01;
   localparam logic [1:0] RX_HSYN = 2'b10;
   localparam logic [1:0] RX_HRX  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_TUNE,
      S_HOP
   } state_t;

   state_t                   state_q, state_d;
   logic [1:0]               rs_q, rs_prev_q;
   logic [HOP_IDX_WIDTH:0]   num_hops_q, num_hops_d;
   logic [HOP_IDX_WIDTH-1:0] seq_q, seq_d;
   logic [HOP_IDX_WIDTH-1:0] seed_q, seed_d;
   logic [PHASE_WIDTH-1:0]   phase_q, phase_d;
   logic [TW-1:0]            tcnt_q, tcnt_d;
   logic                     req_q, req_d;
   logic                     act_q, act_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;

   logic                     start_ev, end_ev, abort_ev, last_hop;
   logic [HOP_IDX_WIDTH:0]   nh_clamp;
   logic [HOP_IDX_WIDTH-1:0] idx_w;
   logic [PHASE_WIDTH-1:0]   phase_calc;

   assign start_ev = (rs_prev_q == RX_INIT) && (rs_q == RX_LOC);
   assign end_ev   = (rs_prev_q == RX_HRX) && (rs_q == RX_INIT);
   assign abort_ev = (rs_q == RX_INIT) &&
                     ((rs_prev_q == RX_LOC) || (rs_prev_q == RX_HSYN));

   assign last_hop = ({1'b0, seq_q} == (num_hops_q - NH_ONE));

   // Full-length sweeps can be visited in XOR order; shorter ones stay linear.
`ifdef TAG_HOP_SCHED_SHUFFLE_EN
   assign idx_w = (num_hops_q == NH_MAX) ? (seq_q ^ seed_q) : seq_q;
`else
   assign idx_w = seq_q;
`endif

   assign phase_calc = cfg_base_inc + cfg_step_inc * PHASE_WIDTH'(idx_w);

   always_comb begin
      nh_clamp = cfg_num_hops;
      if (cfg_num_hops == '0) begin
         nh_clamp = NH_ONE;
      end else if (cfg_num_hops > NH_MAX) begin
         nh_clamp = NH_MAX;
      end
   end

   always_comb begin
      state_d    = state_q;
      num_hops_d = num_hops_q;
      seq_d      = seq_q;
      seed_d     = seed_q;
      phase_d    = phase_q;
      tcnt_d     = tcnt_q;
      req_d      = req_q;
      act_d      = act_q;
      done_d     = 1'b0;
      err_d      = err_q;

      if (!enable) begin
         state_d    = S_IDLE;
         num_hops_d = '0;
         seq_d      = '0;
         seed_d     = '0;
         phase_d    = '0;
         tcnt_d     = '0;
         req_d      = 1'b0;
         act_d      = 1'b0;
         err_d      = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               num_hops_d = nh_clamp;
               seq_d      = '0;
`ifdef TAG_HOP_SCHED_SHUFFLE_EN
               seed_d     = cfg_seed;
`endif
               state_d    = S_ARM;
            end
            S_ARM: begin
               if (start_ev) begin
                  phase_d = phase_calc;
                  tcnt_d  = '0;
                  req_d   = 1'b1;
                  state_d = S_TUNE;
               end
            end
            S_TUNE: begin
               // An aborted hop beats a same-cycle ack; ack beats timeout.
               if (abort_ev) begin
                  req_d   = 1'b0;
                  state_d = S_ARM;
               end else if (tune_ack) begin
                  req_d   = 1'b0;
                  act_d   = 1'b1;
                  state_d = S_HOP;
               end else if (tcnt_q == TO_MAX) begin
                  req_d   = 1'b0;
                  err_d   = 1'b1;
                  state_d = S_HOP;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            S_HOP: begin
               if (abort_ev) begin
                  act_d   = 1'b0;
                  state_d = S_ARM;
               end else if (end_ev) begin
                  act_d   = 1'b0;
                  state_d = S_ARM;
                  if (last_hop) begin
                     done_d = 1'b1;
                     seq_d  = '0;
                  end else begin
                     seq_d = seq_q + SEQ_ONE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         rs_q       <= RX_INIT;
         rs_prev_q  <= RX_INIT;
         num_hops_q <= '0;
         seq_q      <= '0;
         seed_q     <= '0;
         phase_q    <= '0;
         tcnt_q     <= '0;
         req_q      <= 1'b0;
         act_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rs_q       <= rx_state;
         rs_prev_q  <= rs_q;
         num_hops_q <= num_hops_d;
         seq_q      <= seq_d;
         seed_q     <= seed_d;
         phase_q    <= phase_d;
         tcnt_q     <= tcnt_d;
         req_q      <= req_d;
         act_q      <= act_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign tune_req       = req_q;
   assign tune_phase_inc = phase_q;
   assign hop_idx        = idx_w;
   assign hop_active     = act_q;
   assign sweep_done     = done_q;
   assign tune_err       = err_q;

endmodule

// File: tb/tb_tag_hop_scheduler.sv
// tb_tag_hop_scheduler: directed and random checks of tag_hop_scheduler
// against a hop-level reference model.
module tb_tag_hop_scheduler;

   localparam int PW = 24;
   localparam int NH = 64;
   localparam int IW = 6;
   localparam int TO = 15;
`ifdef TAG_HOP_SCHED_SHUFFLE_EN
   localparam bit SHUF = 1'b1;
`else
   localparam bit SHUF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic [1:0]    rx_state = 2'b00;
   logic [IW:0]   cfg_num_hops = '0;
   logic [PW-1:0] cfg_base_inc = '0;
   logic [PW-1:0] cfg_step_inc = '0;
   logic [IW-1:0] cfg_seed = '0;
   logic          tune_ack = 1'b0;
   logic          tune_req;
   logic [PW-1:0] tune_phase_inc;
   logic [IW-1:0] hop_idx;
   logic          hop_active;
   logic          sweep_done;
   logic          tune_err;

   tag_hop_scheduler #(
      .PHASE_WIDTH(PW),
      .NUM_HOPS(NH),
      .HOP_IDX_WIDTH(IW),
      .ACK_TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .rx_state(rx_state),
      .cfg_num_hops(cfg_num_hops),
      .cfg_base_inc(cfg_base_inc),
      .cfg_step_inc(cfg_step_inc),
`ifdef TAG_HOP_SCHED_SHUFFLE_EN
      .cfg_seed(cfg_seed),
`endif
      .tune_req(tune_req),
      .tune_phase_inc(tune_phase_inc),
      .tune_ack(tune_ack),
      .hop_idx(hop_idx),
      .hop_active(hop_active),
      .sweep_done(sweep_done),
      .tune_err(tune_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: hop bookkeeping straight from the rx_state rules.
   localparam int IDLE = 0, ARM = 1, TUNE = 2, HOP = 3;
   int            m_rs, m_prev, m_mode, m_nh, m_seq, m_seed, m_tcnt;
   logic [PW-1:0] m_phase;
   bit            m_req, m_act, m_done, m_err;
   bit            ev_st, ev_end, ev_ab;
   longint        m_p;

   function automatic int m_idx();
      return (SHUF && m_nh == NH) ? (m_seq ^ m_seed) : m_seq;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_rs = 0; m_prev = 0; m_mode = IDLE; m_nh = 0; m_seq = 0;
         m_seed = 0; m_tcnt = 0; m_phase = '0;
         m_req = 0; m_act = 0; m_done = 0; m_err = 0;
      end else begin
         ev_st  = (m_prev == 0 && m_rs == 1);
         ev_end = (m_prev == 3 && m_rs == 0);
         ev_ab  = (m_rs == 0 && (m_prev == 1 || m_prev == 2));
         m_done = 0;
         if (!enable) begin
            m_mode = IDLE; m_nh = 0; m_seq = 0; m_seed = 0;
            m_phase = '0; m_req = 0; m_act = 0; m_err = 0;
         end else begin
            case (m_mode)
               IDLE: begin
                  if (cfg_num_hops == 0) m_nh = 1;
                  else if (int'(cfg_num_hops) > NH) m_nh = NH;
                  else m_nh = int'(cfg_num_hops);
                  m_seq = 0;
                  m_seed = int'(cfg_seed);
                  m_mode = ARM;
               end
               ARM: if (ev_st) begin
                  m_p = longint'(cfg_base_inc) +
                        longint'(m_idx()) * longint'(cfg_step_inc);
                  m_phase = m_p[PW-1:0];
                  m_req = 1; m_tcnt = 0; m_mode = TUNE;
               end
               TUNE: begin
                  if (ev_ab) begin
                     m_req = 0; m_mode = ARM;
                  end else if (tune_ack) begin
                     m_req = 0; m_act = 1; m_mode = HOP;
                  end else if (m_tcnt == TO) begin
                     m_req = 0; m_err = 1; m_mode = HOP;
                  end else begin
                     m_tcnt++;
                  end
               end
               default: begin
                  if (ev_ab) begin
                     m_act = 0; m_mode = ARM;
                  end else if (ev_end) begin
                     m_act = 0; m_mode = ARM;
                     if (m_seq == m_nh - 1) begin
                        m_done = 1; m_seq = 0;
                     end else begin
                        m_seq++;
                     end
                  end
               end
            endcase
         end
         m_prev = m_rs;
         m_rs = int'(rx_state);
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         chk("tune_req", tune_req, m_req);
         chk("hop_active", hop_active, m_act);
         chk("sweep_done", sweep_done, m_done);
         chk("tune_err", tune_err, m_err);
         chk("hop_idx", hop_idx, m_idx());
         if (m_req) chk("tune_phase_inc", tune_phase_inc, m_phase);
      end
   end

   // Observers used by the directed literal checks.
   bit            req_prev = 0;
   int            req_run = 0, last_run = 0, n_sweep = 0;
   logic [PW-1:0] last_phase = '0;
   int            tune_log[$];
   bit            act_after_ack = 0, req_after_ack = 1;

   always @(negedge clk) begin
      if (tune_req) begin
         req_run++;
         if (!req_prev) begin
            last_phase = tune_phase_inc;
            tune_log.push_back(int'(hop_idx));
         end
      end else if (req_prev) begin
         last_run = req_run;
         req_run = 0;
      end
      if (sweep_done) n_sweep++;
      req_prev = tune_req;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic finish_hop();
      rx_state = 2'b10; tick(1);
      rx_state = 2'b11; tick(2);
      rx_state = 2'b00; tick(3);
   endtask

   task automatic run_hop(input int ack_dly, input bit fin);
      bit seen;
      seen = 0;
      rx_state = 2'b01;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick(1);
         seen = tune_req;
      end
      chk("tune_req_rise", tune_req, 1'b1);
      if (seen) begin
         if (ack_dly >= 0) begin
            tick(ack_dly);
            tune_ack = 1'b1;
            tick(1);
            tune_ack = 1'b0;
            act_after_ack = hop_active;
            req_after_ack = tune_req;
         end else begin
            tick(TO + 4);
         end
      end
      if (fin) finish_hop();
   endtask

   task automatic restart(input int nh);
      enable = 1'b0; tick(2);
      cfg_num_hops = (IW+1)'(nh);
      enable = 1'b1; tick(2);
   endtask

   int n0, r, seen_cnt;
   bit seen_map[NH];

   initial begin
      tick(3);
      chk("rst_tune_req", tune_req, 1'b0);
      chk("rst_hop_active", hop_active, 1'b0);
      chk("rst_sweep_done", sweep_done, 1'b0);
      chk("rst_tune_err", tune_err, 1'b0);
      chk("rst_hop_idx", hop_idx, 0);
      reset_n = 1'b1;

      // Normal hop at index 2
      cfg_base_inc = 24'h001000;
      cfg_step_inc = 24'h000100;
      restart(8);
      run_hop(1, 1);
      run_hop(1, 1);
      chk("hop_idx_pre", hop_idx, 2);
      run_hop(3, 1);
      chk("phase_hop2", last_phase, 24'h001200);
      chk("req_len_ack3", last_run, 4);
      chk("act_after_ack", act_after_ack, 1'b1);
      chk("req_after_ack", req_after_ack, 1'b0);
      chk("hop_idx_adv", hop_idx, 3);

      // Sweep wrap with four hops
      restart(4);
      n0 = n_sweep;
      for (int h = 0; h < 3; h++) run_hop(2, 1);
      chk("no_early_sweep", n_sweep - n0, 0);
      run_hop(2, 1);
      chk("sweep_once", n_sweep - n0, 1);
      chk("hop_idx_wrap", hop_idx, 0);
      run_hop(2, 1);
      chk("phase_after_wrap", last_phase, 24'h001000);

      // Async reset while tuning
      rx_state = 2'b01;
      for (int i = 0; i < 8 && !tune_req; i++) tick(1);
      chk("pre_reset_req", tune_req, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("arst_tune_req", tune_req, 1'b0);
      chk("arst_hop_active", hop_active, 1'b0);
      chk("arst_sweep_done", sweep_done, 1'b0);
      chk("arst_tune_err", tune_err, 1'b0);
      chk("arst_hop_idx", hop_idx, 0);
      rx_state = 2'b00;
      tick(2);
      reset_n = 1'b1;
      tick(3);
      run_hop(1, 1);
      chk("hop_idx_post_reset", hop_idx, 1);

      // Ack timeout, sticky error
      restart(8);
      run_hop(-1, 0);
      chk("timeout_req_len", last_run, 16);
      chk("timeout_err", tune_err, 1'b1);
      chk("timeout_no_act", hop_active, 1'b0);
      finish_hop();
      chk("timeout_hop_counts", hop_idx, 1);
      run_hop(1, 1);
      chk("err_sticky", tune_err, 1'b1);
      enable = 1'b0; tick(2);
      chk("err_clear", tune_err, 1'b0);

      // Phase wrap, then abort on the last hop
      cfg_base_inc = 24'hFFFF00;
      cfg_step_inc = 24'h000200;
      restart(3);
      run_hop(1, 1);
      run_hop(1, 1);
      chk("phase_wrap", last_phase, 24'h000100);
      n0 = n_sweep;
      run_hop(1, 0);
      rx_state = 2'b00; tick(3);
      chk("abort_idx", hop_idx, 2);
      chk("abort_act", hop_active, 1'b0);
      chk("abort_no_sweep", n_sweep - n0, 0);
      run_hop(1, 1);
      chk("sweep_after_abort", n_sweep - n0, 1);
      chk("idx_after_abort_sweep", hop_idx, 0);

      if (SHUF) begin
         cfg_seed = 6'h2A;
         cfg_base_inc = 24'h000000;
         cfg_step_inc = 24'h000001;
         restart(64);
         tune_log.delete();
         n0 = n_sweep;
         for (int h = 0; h < 64; h++) run_hop(0, 1);
         chk("shuf_len", tune_log.size(), 64);
         chk("shuf_0", tune_log[0], 32'h2A);
         chk("shuf_1", tune_log[1], 32'h2B);
         chk("shuf_2", tune_log[2], 32'h28);
         foreach (seen_map[i]) seen_map[i] = 0;
         foreach (tune_log[i]) seen_map[tune_log[i] % NH] = 1;
         seen_cnt = 0;
         foreach (seen_map[i]) seen_cnt += int'(seen_map[i]);
         chk("shuf_cover", seen_cnt, 64);
         chk("shuf_sweep", n_sweep - n0, 1);
      end

      // Randomized traffic
      restart(4);
      for (int c = 0; c < 6000; c++) begin
         if (c == 3000) begin
            reset_n = 1'b0; tick(2); reset_n = 1'b1;
         end
         if ($urandom_range(0, 299) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
         if ($urandom_range(0, 99) == 0) begin
            if ($urandom_range(0, 3) == 0)
               cfg_num_hops = (IW+1)'($urandom_range(0, 127));
            else
               cfg_num_hops = (IW+1)'($urandom_range(0, 6));
            cfg_base_inc = PW'($urandom);
            cfg_step_inc = PW'($urandom);
            cfg_seed = IW'($urandom);
         end
         r = $urandom_range(0, 99);
         if (r < 25) rx_state = rx_state + 2'd1;
         else if (r < 28) rx_state = 2'b00;
         else if (r < 30) rx_state = 2'($urandom);
         tune_ack = ($urandom_range(0, 9) == 0);
         tick(1);
      end
      tune_ack = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
